param_register_file: RTL and testbench
======================================

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 XLEN, default 32, data word width in bits.
REQ-002 AW, default 5, address width; depth NREGS = 2**AW.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 we  input  1  write enable.
REQ-006 wa  input  AW  write address.
REQ-007 wd  input  XLEN  write data.
REQ-008 ra1, ra2  input  AW each  read addresses, ports 1 and 2.
REQ-009 rd1, rd2  output  XLEN each  read data, ports 1 and 2.
REQ-010 dbg_ra  input  AW  debug read address.
REQ-011 dbg_rd  output  XLEN  debug read data.
REQ-012 clr_req  input  1  request a full clear of all entries.
REQ-013 busy  output  1  clear sequence in progress.
REQ-014 wr_err  output  1  sticky flag: a write was dropped.

Function
REQ-015 Entry 0 shall read as zero on every port at all times; writes to address 0 shall be discarded without error.
REQ-016 Writes shall commit on the rising clk edge when we=1, busy=0 and wa!=0.
REQ-017 Read ports shall be combinational; rd1 and rd2 shall return 0 while busy=1.
REQ-018 Bypass: when we=1, busy=0, wa!=0 and raN==wa, rdN shall return wd in the same cycle.
REQ-019 dbg_rd shall return stored contents only, with no bypass, and 0 while busy=1.
REQ-020 The FSM shall have two states, CLEAR and READY; busy = (state==CLEAR).
REQ-021 CLEAR: an AW-bit counter cnt shall start at 1; each rising edge writes 0 to entry cnt and increments cnt.
REQ-022 CLEAR -> READY on the edge where entry NREGS-1 is cleared, so CLEAR lasts exactly NREGS-1 cycles.
REQ-023 READY -> CLEAR on a rising edge with clr_req=1, with cnt reloaded to 1.
REQ-024 clr_req while in CLEAR shall be ignored; the sequence shall not restart.
REQ-025 If we=1, wa!=0 and busy=1 on a rising edge, the write shall be dropped and wr_err set to 1.
REQ-026 wr_err shall remain set until rst; clr_req shall not clear it.
REQ-027 If we=1 and clr_req=1 in READY on the same edge, the write shall commit and then be overwritten during the clear.
REQ-028 Parameters shall be legal for AW 2..8 and XLEN 1..64 with no width truncation of cnt.

Reset
REQ-029 While rst=1: state=CLEAR, cnt=1, busy=1, wr_err=0, rd1=rd2=dbg_rd=0.
REQ-030 After rst falls, the clear shall run per REQ-021/022; busy shall fall after NREGS-1 rising edges.
REQ-031 rst asserted mid-clear shall immediately restart the sequence at cnt=1.
REQ-032 Array contents shall need no reset other than the clear sequence.

Verification
REQ-033 Assert rst, release, and count edges with busy=1 (default params) -> exactly 31, then busy=0; all 32 entries read 0 via dbg_ra sweep.
REQ-034 Write 0xDEADBEEF to x5 with ra1=5 in the same cycle -> rd1=0xDEADBEEF that cycle (bypass) and dbg_rd(5) shows it from the next cycle.
REQ-035 Write 0x12345678 to x0 -> rd1, rd2 and dbg_rd at address 0 stay 0; wr_err stays 0.
REQ-036 Pulse clr_req, then write x3=0xA5A5A5A5 while busy=1 -> write lost, wr_err=1, x3 reads 0 after busy falls.
REQ-037 Assert rst at clear cycle 10 for 1 cycle -> busy stays high and falls 31 edges after the rst release; wr_err=0.
REQ-038 Parameter sweep AW=3, XLEN=8: CLEAR lasts 7 cycles; write x7=0xFF -> rd2(7)=0xFF; bypass and x0 rules hold.

Source files
------------

// File: rtl/param_register_file.sv
// Parameterised register file with two bypassed read ports, a debug port and a
// self-running clear sequence that sweeps entries 1..NREGS-1 to zero.
module param_register_file #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic [AW-1:0]   dbg_ra,
  output logic [XLEN-1:0] dbg_rd,
  input  logic            clr_req,
  output logic            busy,
  output logic            wr_err
);

  localparam int            NREGS = 2 ** AW;
  localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t          state;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] mem [NREGS];
  logic            wr_req;
  logic            wr_ok;

  assign busy   = (state == CLEAR);
  assign wr_req = we && (wa != '0);
  assign wr_ok  = wr_req && !busy;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= CLEAR;
      cnt    <= AW'(1);
      wr_err <= 1'b0;
    end else begin
      if (wr_req && busy) wr_err <= 1'b1;
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= READY;
        end
        READY: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= AW'(1);
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // NOTE: the array has no reset; the clear sweep zeroes it after every rst,
  // and entry 0 is never stored because every read port masks it.
  always_ff @(posedge clk) begin
    if (busy)       mem[cnt] <= '0;
    else if (wr_ok) mem[wa]  <= wd;
  end

  // NOTE: every output gets a default before the conditionals, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    rd1    = '0;
    rd2    = '0;
    dbg_rd = '0;
    if (!busy) begin
      if (ra1 != '0)    rd1    = (wr_ok && ra1 == wa) ? wd : mem[ra1];
      if (ra2 != '0)    rd2    = (wr_ok && ra2 == wa) ? wd : mem[ra2];
      if (dbg_ra != '0) dbg_rd = mem[dbg_ra];
    end
  end

endmodule

// File: tb/tb_param_register_file.sv
// Self-checking bench for param_register_file: directed table, clear/reset
// corner sequences, randomized traffic against an array model, and an AW=3/XLEN=8 instance.
module tb_param_register_file;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, we, clr_req, busy, wr_err;
  logic [AW-1:0]   wa, ra1, ra2, dbg_ra;
  logic [XLEN-1:0] wd, rd1, rd2, dbg_rd;

  logic       p_rst, p_we, p_clr_req, p_busy, p_wr_err;
  logic [2:0] p_wa, p_ra1, p_ra2, p_dbg_ra;
  logic [7:0] p_wd, p_rd1, p_rd2, p_dbg_rd;

  param_register_file #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2), .dbg_ra(dbg_ra), .dbg_rd(dbg_rd), .clr_req(clr_req),
    .busy(busy), .wr_err(wr_err)
  );

  param_register_file #(.XLEN(8), .AW(3)) dut_small (
    .clk(clk), .rst(p_rst), .we(p_we), .wa(p_wa), .wd(p_wd), .ra1(p_ra1), .ra2(p_ra2),
    .rd1(p_rd1), .rd2(p_rd2), .dbg_ra(p_dbg_ra), .dbg_rd(p_dbg_rd), .clr_req(p_clr_req),
    .busy(p_busy), .wr_err(p_wr_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the array's visible contents plus how many clear edges remain.
  // A clear is modelled as wiping everything at once; reads are masked while it runs.
  logic [XLEN-1:0] m_mem [NREGS];
  int              m_left;
  bit              m_err;

  task automatic model_wipe();
    for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
    m_left = NREGS - 1;
  endtask

  task automatic model_reset();
    model_wipe();
    m_err = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] ra, input bit bypass);
    if (m_left > 0 || ra == 0) return '0;
    if (bypass && we && wa != 0 && ra == wa) return wd;
    return m_mem[ra];
  endfunction

  task automatic model_edge();
    if (rst) model_reset();
    else if (m_left > 0) begin
      if (we && wa != 0) m_err = 1'b1;
      m_left--;
    end else begin
      if (we && wa != 0) m_mem[wa] = wd;
      if (clr_req) model_wipe();
    end
  endtask

  task automatic model_check(input string tag);
    check({tag, ".busy"},   busy,   m_left > 0);
    check({tag, ".rd1"},    rd1,    m_read(ra1, 1'b1));
    check({tag, ".rd2"},    rd2,    m_read(ra2, 1'b1));
    check({tag, ".dbg_rd"}, dbg_rd, m_read(dbg_ra, 1'b0));
    check({tag, ".wr_err"}, wr_err, m_err);
  endtask

  // One rising edge with the current inputs; returns just after the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; dbg_ra = '0; clr_req = 1'b0;
  endtask

  // Counts rising edges until busy drops, with a bounded budget.
  task automatic count_clear(input string name, input int exp);
    int edges = 0;
    #1;
    while (busy && edges < 200) begin
      step();
      edges++;
      #1;
    end
    check(name, edges, exp);
  endtask

  typedef struct {
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic [AW-1:0]   ra1, ra2, dbg;
    logic [XLEN-1:0] e1, e2, ed;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0};
    tbl[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0};
    tbl[4] = '{1'b1, 5'd9, 32'h11111111, 5'd9, 5'd5, 5'd9, 32'h11111111, 32'hDEADBEEF, 32'h0};
    tbl[5] = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 5'd9, 32'h11111111, 32'h11111111, 32'h11111111};

    idle();
    p_we = 1'b0; p_wa = '0; p_wd = '0; p_ra1 = '0; p_ra2 = '0; p_dbg_ra = '0; p_clr_req = 1'b0;
    rst = 1'b1; p_rst = 1'b1;
    model_reset();

    // Reset state, with nonzero read addresses
    @(negedge clk);
    ra1 = 5'd3; ra2 = 5'd31; dbg_ra = 5'd7;
    #1;
    check("reset.busy", busy, 1'b1);
    check("reset.rd1", rd1, 0);
    check("reset.rd2", rd2, 0);
    check("reset.dbg_rd", dbg_rd, 0);
    check("reset.wr_err", wr_err, 1'b0);
    step();
    idle();

    // Clear after reset lasts NREGS-1 edges, then every entry reads zero
    rst = 1'b0;
    count_clear("post_reset_clear_len", NREGS - 1);
    for (int i = 0; i < NREGS; i++) begin
      dbg_ra = AW'(i);
      #1;
      check($sformatf("sweep.dbg_rd[%0d]", i), dbg_rd, 0);
      step();
    end
    idle();

    // Directed table: bypass, commit, and writes to x0
    for (int i = 0; i < 6; i++) begin
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      ra1 = tbl[i].ra1; ra2 = tbl[i].ra2; dbg_ra = tbl[i].dbg;
      #1;
      check($sformatf("tbl%0d.rd1", i), rd1, tbl[i].e1);
      check($sformatf("tbl%0d.rd2", i), rd2, tbl[i].e2);
      check($sformatf("tbl%0d.dbg_rd", i), dbg_rd, tbl[i].ed);
      model_check($sformatf("tbl%0d", i));
      step();
    end
    #1;
    check("x0_write.wr_err", wr_err, 1'b0);
    idle();

    // Write dropped during clear sets wr_err; clr_req held during clear is ignored
    we = 1'b1; wa = 5'd3; wd = 32'h00000077;
    step();
    idle();
    clr_req = 1'b1;
    #1;
    model_check("clr_pulse");
    step();
    we = 1'b1; wa = 5'd3; wd = 32'hA5A5A5A5;
    count_clear("held_clr_len", NREGS - 1);
    idle();
    ra1 = 5'd3; dbg_ra = 5'd3;
    #1;
    check("dropped.wr_err", wr_err, 1'b1);
    check("dropped.rd1", rd1, 0);
    check("dropped.dbg_rd", dbg_rd, 0);
    model_check("dropped");
    step();

    // Write and clr_req on the same edge: write commits, then gets cleared
    we = 1'b1; wa = 5'd7; wd = 32'hCAFEF00D; ra1 = 5'd7; clr_req = 1'b1;
    #1;
    check("wr_clr.bypass", rd1, 32'hCAFEF00D);
    step();
    idle();
    count_clear("wr_clr_len", NREGS - 1);
    ra1 = 5'd7; dbg_ra = 5'd7;
    #1;
    check("wr_clr.rd1", rd1, 0);
    check("wr_clr.dbg_rd", dbg_rd, 0);
    check("wr_clr.wr_err_sticky", wr_err, 1'b1);
    step();
    idle();

    // rst pulse at clear cycle 10 restarts the sweep and clears wr_err
    rst = 1'b1; model_reset();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1; model_reset();
    #1;
    check("midclr_rst.busy", busy, 1'b1);
    check("midclr_rst.wr_err", wr_err, 1'b0);
    step();
    rst = 1'b0;
    count_clear("midclr_rst_len", NREGS - 1);
    check("midclr_rst.wr_err_after", wr_err, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      wa = AW'($urandom);
      wd = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      ra2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      dbg_ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      clr_req = ($urandom_range(0, 59) == 0);
      #1;
      model_check("rand");
      step();
    end
    idle();

    // Small instance: AW=3, XLEN=8
    p_rst = 1'b0;
    begin
      int edges = 0;
      #1;
      while (p_busy && edges < 100) begin
        step();
        edges++;
        #1;
      end
      check("small.clear_len", edges, 7);
    end
    p_we = 1'b1; p_wa = 3'd7; p_wd = 8'hFF; p_ra1 = 3'd7; p_ra2 = 3'd7; p_dbg_ra = 3'd7;
    #1;
    check("small.bypass_rd2", p_rd2, 8'hFF);
    check("small.bypass_rd1", p_rd1, 8'hFF);
    check("small.dbg_no_bypass", p_dbg_rd, 0);
    step();
    p_we = 1'b0;
    #1;
    check("small.rd2", p_rd2, 8'hFF);
    check("small.dbg_rd", p_dbg_rd, 8'hFF);
    p_we = 1'b1; p_wa = 3'd0; p_wd = 8'hAB; p_ra1 = 3'd0; p_ra2 = 3'd0; p_dbg_ra = 3'd0;
    #1;
    check("small.x0_rd1_bypass", p_rd1, 0);
    step();
    p_we = 1'b0;
    #1;
    check("small.x0_rd1", p_rd1, 0);
    check("small.x0_rd2", p_rd2, 0);
    check("small.x0_dbg", p_dbg_rd, 0);
    check("small.wr_err", p_wr_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
